// File: rtl/timer_pkg.sv
// Shared definitions for the timer APB arbiter slice.
//   - arb_state_e : APB master sequencing states
//   - TIMER_ADDR_W / TIMER_DATA_W : register bus geometry
//   - TIMER_ARB_TIMEOUT_DEFAULT : default ACCESS timeout, used when
//     TIMER_APB_ARB_TIMEOUT_EN is defined
package timer_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_e;

  localparam int TIMER_ADDR_W              = 13;
  localparam int TIMER_DATA_W              = 32;
  localparam int TIMER_ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/timer_rr_arbiter.sv
// 2-way round-robin arbiter.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req_i[1:0]   : request vector
//   grant_en_i   : pointer may advance this cycle (a grant is being taken)
//   gnt_o[1:0]   : one-hot grant (all zero when no request)
// The pointer holds the index of the last granted requester and resets to 1
// so requester 0 wins the first tie.
module timer_rr_arbiter
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  // A single requester is already one-hot; on a tie the one not granted
  // last wins.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (grant_en_i && (req_i != 2'b00)) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/timer_apb_arbiter.sv
// Two-requester APB master arbiter in front of the timer register slave.
// Each requester raises req_valid and holds it until its req_done pulse;
// the block grants round-robin, runs one IDLE/SETUP/ACCESS APB transfer
// and returns read data / error status in a one-cycle RESP.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_write[1:0]       : per-requester request and direction
//   req_addr/req_wdata/req_strb    : packed per-requester fields, req 0 low
//   req_done[1:0]                  : completion pulse to granted requester
//   req_rdata, req_err             : response, valid with req_done
//   psel, penable, pwrite, paddr,
//   pwdata, pstrb                  : registered APB master outputs
//   prdata, pready, pslverr        : APB slave response
// Optional feature: define TIMER_APB_ARB_TIMEOUT_EN to force an error
// response after TIMEOUT_CYCLES ACCESS cycles without pready.
module timer_apb_arbiter
  import timer_pkg::*;
#(
  parameter int ADDR_W         = TIMER_ADDR_W,
  parameter int DATA_W         = TIMER_DATA_W,
  parameter int TIMEOUT_CYCLES = TIMER_ARB_TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]     req_wdata,
  input  logic [2*(DATA_W/8)-1:0] req_strb,
  output logic [1:0]              req_done,
  output logic [DATA_W-1:0]       req_rdata,
  output logic                    req_err,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_W-1:0]       paddr,
  output logic [DATA_W-1:0]       pwdata,
  output logic [DATA_W/8-1:0]     pstrb,
  input  logic [DATA_W-1:0]       prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e          state_q;
  logic                grant_q;
  logic [1:0]          gnt;
  logic                sel;
  logic                psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [STRB_W-1:0]   pstrb_q;
  logic [1:0]          done_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
`ifdef TIMER_APB_ARB_TIMEOUT_EN
  logic [15:0]         to_cnt_q;
`endif

  // Requests are only looked at in IDLE, which also keeps a requester's
  // valid during its own RESP cycle from being granted early.
  timer_rr_arbiter u_rr (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_valid),
    .grant_en_i (state_q == ARB_IDLE),
    .gnt_o      (gnt)
  );

  assign sel = gnt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      grant_q   <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef TIMER_APB_ARB_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      done_q <= 2'b00;
      case (state_q)
        ARB_IDLE: begin
          if (req_valid != 2'b00) begin
            grant_q  <= sel;
            pwrite_q <= sel ? req_write[1] : req_write[0];
            paddr_q  <= sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
            pwdata_q <= sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            pstrb_q  <= sel ? req_strb[2*STRB_W-1:STRB_W] : req_strb[STRB_W-1:0];
            psel_q   <= 1'b1;
            state_q  <= ARB_SETUP;
          end
        end
        ARB_SETUP: begin
          penable_q <= 1'b1;
`ifdef TIMER_APB_ARB_TIMEOUT_EN
          to_cnt_q  <= '0;
`endif
          state_q   <= ARB_ACCESS;
        end
        ARB_ACCESS: begin
          if (pready) begin
            rdata_q   <= pwrite_q ? '0 : prdata;
            err_q     <= pslverr;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= grant_q ? 2'b10 : 2'b01;
            state_q   <= ARB_RESP;
          end
`ifdef TIMER_APB_ARB_TIMEOUT_EN
          // Counter value is the number of stalled cycles already seen; this
          // stalled cycle is the one that makes it reach TIMEOUT_CYCLES.
          else if (to_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= grant_q ? 2'b10 : 2'b01;
            state_q   <= ARB_RESP;
          end else begin
            to_cnt_q  <= to_cnt_q + 16'd1;
          end
`endif
        end
        ARB_RESP: begin
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pstrb     = pstrb_q;
  assign req_done  = done_q;
  assign req_rdata = rdata_q;
  assign req_err   = err_q;

endmodule
